// File: rtl/ppu_types.sv
// rtl/ppu_types.sv - shared types and constants for the PPU timing controller
package ppu_types;

    typedef enum logic [1:0] {
        PPU_MODE_0 = 2'd0,
        PPU_MODE_1 = 2'd1,
        PPU_MODE_2 = 2'd2,
        PPU_MODE_3 = 2'd3
    } ppu_mode_t;

    localparam logic [15:0] ADDR_LCDC = 16'hFF40;
    localparam logic [15:0] ADDR_STAT = 16'hFF41;
    localparam logic [15:0] ADDR_LY   = 16'hFF44;
    localparam logic [15:0] ADDR_LYC  = 16'hFF45;

    localparam int LCDC_ON_BIT = 7;

    localparam int STAT_LYC_IE = 6;
    localparam int STAT_M2_IE  = 5;
    localparam int STAT_M1_IE  = 4;
    localparam int STAT_M0_IE  = 3;
    localparam int STAT_COINC  = 2;

    localparam logic [7:0] LCDC_RESET = 8'h91;

    typedef struct packed {
        logic [7:0] lcdc;
        logic [6:3] stat;
        logic [7:0] lyc;
    } ppu_timing_regs_t;

endpackage

// File: rtl/ppu_stat_irq.sv
// rtl/ppu_stat_irq.sv - STAT interrupt line combiner and rising-edge pulse
module ppu_stat_irq
    import ppu_types::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      lcd_on_i,
    input  logic [6:3] stat_en_i,
    input  logic      coinc_i,
    input  ppu_mode_t mode_i,
    output logic      stat_irq_o
);

    logic line_d;
    logic line_q;

    // OR of the enabled sources; the line is held low while the LCD is off
    always_comb begin
        line_d = (stat_en_i[STAT_LYC_IE] & coinc_i)
               | (stat_en_i[STAT_M2_IE] & (mode_i == PPU_MODE_2))
               | (stat_en_i[STAT_M1_IE] & (mode_i == PPU_MODE_1))
               | (stat_en_i[STAT_M0_IE] & (mode_i == PPU_MODE_0));
        if (!lcd_on_i) begin
            line_d = 1'b0;
        end
    end

    // previous line level, so overlapping sources only pulse once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            line_q <= 1'b0;
        end else begin
            line_q <= line_d;
        end
    end

    assign stat_irq_o = line_d & ~line_q;

endmodule

// File: rtl/ppu_timing_ctrl.sv
// rtl/ppu_timing_ctrl.sv - LCD dot/line counters, mode sequencer and LCDC/STAT/LY/LYC registers
module ppu_timing_ctrl
    import ppu_types::*;
#(
    parameter int CYCLES_PER_LINE = 456,
    parameter int VISIBLE_LINES   = 144,
    parameter int LINES_PER_FRAME = 154,
    parameter int MODE2_LEN       = 80,
    parameter int MODE3_MAX_LEN   = 289
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               reg_write_en,
    input  logic [15:0]                        reg_addr,
    input  logic [7:0]                         reg_wdata,
    output logic [7:0]                         reg_rdata,
    output logic                               reg_hit,
    input  logic                               pix_done,
    output ppu_mode_t                          mode,
    output logic [7:0]                         ly,
    output logic [$clog2(CYCLES_PER_LINE)-1:0] dot,
    output logic                               lcd_on,
    output logic                               frame_done,
    output logic                               vblank_irq,
    output logic                               stat_irq
);

    localparam int DOT_W = $clog2(CYCLES_PER_LINE);

    localparam logic [DOT_W-1:0] DOT_LAST     = DOT_W'(CYCLES_PER_LINE - 1);
    localparam logic [DOT_W-1:0] DOT_M3_START = DOT_W'(MODE2_LEN);
    localparam logic [DOT_W-1:0] DOT_M3_LAST  = DOT_W'(MODE2_LEN + MODE3_MAX_LEN - 1);
    localparam logic [7:0]       LY_LAST      = 8'(LINES_PER_FRAME - 1);
    localparam logic [7:0]       LY_VBLANK    = 8'(VISIBLE_LINES);
    localparam logic [7:0]       LY_VIS_LAST  = 8'(VISIBLE_LINES - 1);

    ppu_timing_regs_t regs_q, regs_d;

    logic [DOT_W-1:0] dot_q, dot_d;
    logic [7:0]       ly_q, ly_d;
    ppu_mode_t        mode_q, mode_d;
    logic             frame_done_q, frame_done_d;
    logic             vblank_q, vblank_d;

    logic             coinc;
    logic             lcd_on_next;
    logic [7:0]       stat_rd;

    // register file update from the bus; LY and STAT[2:0] are not writable
    always_comb begin
        regs_d = regs_q;
        if (reg_write_en) begin
            case (reg_addr)
                ADDR_LCDC: regs_d.lcdc = reg_wdata;
                ADDR_STAT: regs_d.stat = reg_wdata[6:3];
                ADDR_LYC:  regs_d.lyc  = reg_wdata;
                default:   ;
            endcase
        end
    end

    // bus-visible register state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regs_q.lcdc <= LCDC_RESET;
            regs_q.stat <= '0;
            regs_q.lyc  <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    // next dot/line/mode; the new LCDC enable is used so an on/off write acts on this edge
    always_comb begin
        lcd_on_next  = regs_d.lcdc[LCDC_ON_BIT];
        dot_d        = dot_q;
        ly_d         = ly_q;
        mode_d       = mode_q;
        frame_done_d = 1'b0;
        vblank_d     = 1'b0;
        if (!lcd_on_next) begin
            dot_d  = '0;
            ly_d   = '0;
            mode_d = PPU_MODE_0;
        end else if (!regs_q.lcdc[LCDC_ON_BIT]) begin
            dot_d  = '0;
            ly_d   = '0;
            mode_d = PPU_MODE_2;
        end else begin
            if (dot_q == DOT_LAST) begin
                dot_d        = '0;
                ly_d         = (ly_q == LY_LAST) ? 8'd0 : ly_q + 8'd1;
                frame_done_d = (ly_q == LY_LAST);
                vblank_d     = (ly_q == LY_VIS_LAST);
            end else begin
                dot_d = dot_q + DOT_W'(1);
            end
            if (ly_d >= LY_VBLANK) begin
                mode_d = PPU_MODE_1;
            end else if (dot_d < DOT_M3_START) begin
                mode_d = PPU_MODE_2;
            end else if (dot_d == DOT_M3_START) begin
                mode_d = PPU_MODE_3;
            end else if (mode_q == PPU_MODE_3 && (pix_done || dot_q == DOT_M3_LAST)) begin
                mode_d = PPU_MODE_0;
            end
        end
    end

    // timing state and the registered frame/V-blank pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dot_q        <= '0;
            ly_q         <= '0;
            mode_q       <= PPU_MODE_2;
            frame_done_q <= 1'b0;
            vblank_q     <= 1'b0;
        end else begin
            dot_q        <= dot_d;
            ly_q         <= ly_d;
            mode_q       <= mode_d;
            frame_done_q <= frame_done_d;
            vblank_q     <= vblank_d;
        end
    end

    assign coinc = (ly_q == regs_q.lyc);

    // combinational register read mux
    always_comb begin
        stat_rd             = 8'h80;
        stat_rd[6:3]        = regs_q.stat;
        stat_rd[STAT_COINC] = coinc;
        stat_rd[1:0]        = mode_q;
        reg_rdata           = 8'h00;
        reg_hit             = 1'b0;
        case (reg_addr)
            ADDR_LCDC: begin reg_hit = 1'b1; reg_rdata = regs_q.lcdc; end
            ADDR_STAT: begin reg_hit = 1'b1; reg_rdata = stat_rd;     end
            ADDR_LY:   begin reg_hit = 1'b1; reg_rdata = ly_q;        end
            ADDR_LYC:  begin reg_hit = 1'b1; reg_rdata = regs_q.lyc;  end
            default:   ;
        endcase
    end

    ppu_stat_irq u_stat_irq (
        .clk        (clk),
        .reset      (reset),
        .lcd_on_i   (regs_q.lcdc[LCDC_ON_BIT]),
        .stat_en_i  (regs_q.stat),
        .coinc_i    (coinc),
        .mode_i     (mode_q),
        .stat_irq_o (stat_irq)
    );

    assign mode       = mode_q;
    assign ly         = ly_q;
    assign dot        = dot_q;
    assign lcd_on     = regs_q.lcdc[LCDC_ON_BIT];
    assign frame_done = frame_done_q;
    assign vblank_irq = vblank_q;

endmodule

// File: tb/tb_ppu_timing_ctrl.sv
// tb/tb_ppu_timing_ctrl.sv - scoreboard bench for ppu_timing_ctrl against a behavioural frame model
module tb_ppu_timing_ctrl;
    import ppu_types::*;

    localparam int CPL   = 456;
    localparam int VIS   = 144;
    localparam int LPF   = 154;
    localparam int M2    = 80;
    localparam int M3MAX = 289;
    localparam int M3END = M2 + M3MAX - 1;
    localparam int LIMIT = 80000;

    logic        clk = 1'b0;
    logic        reset;
    logic        reg_write_en;
    logic [15:0] reg_addr;
    logic [7:0]  reg_wdata;
    logic [7:0]  reg_rdata;
    logic        reg_hit;
    logic        pix_done;
    ppu_mode_t   mode;
    logic [7:0]  ly;
    logic [8:0]  dot;
    logic        lcd_on;
    logic        frame_done;
    logic        vblank_irq;
    logic        stat_irq;

    ppu_timing_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .reg_write_en (reg_write_en),
        .reg_addr     (reg_addr),
        .reg_wdata    (reg_wdata),
        .reg_rdata    (reg_rdata),
        .reg_hit      (reg_hit),
        .pix_done     (pix_done),
        .mode         (mode),
        .ly           (ly),
        .dot          (dot),
        .lcd_on       (lcd_on),
        .frame_done   (frame_done),
        .vblank_irq   (vblank_irq),
        .stat_irq     (stat_irq)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_q[$];
    int mon_cyc = 0;
    int fd_cnt  = 0;
    int vb_cnt  = 0;

    // reference model: frame position plus where mode 3 ends on the current line
    bit [7:0] m_lcdc;
    bit [3:0] m_stat;
    int       m_lyc;
    int       m_ly;
    int       m_dot;
    int       m_m3end;
    bit       m_lineq;
    bit       m_fd;
    bit       m_vb;
    int       m_frames;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic int m_mode();
        if (!m_lcdc[7])       return 0;
        if (m_ly >= VIS)      return 1;
        if (m_dot < M2)       return 2;
        if (m_dot <= m_m3end) return 3;
        return 0;
    endfunction

    function automatic bit m_line();
        int md;
        md = m_mode();
        if (!m_lcdc[7]) return 1'b0;
        return (m_stat[3] && m_ly == m_lyc) || (m_stat[2] && md == 2) ||
               (m_stat[1] && md == 1) || (m_stat[0] && md == 0);
    endfunction

    function automatic logic [8:0] m_rdata(input logic [15:0] a);
        logic [7:0] st;
        st = {1'b1, m_stat, (m_ly == m_lyc), 2'(m_mode())};
        case (a)
            16'hFF40: return {1'b1, m_lcdc};
            16'hFF41: return {1'b1, st};
            16'hFF44: return {1'b1, 8'(m_ly)};
            16'hFF45: return {1'b1, 8'(m_lyc)};
            default:  return 9'h000;
        endcase
    endfunction

    function automatic logic [31:0] pack(input logic on, input logic [1:0] md, input logic [7:0] l,
                                         input logic [8:0] d, input logic f, input logic v,
                                         input logic s, input logic [7:0] rd, input logic h);
        return {on, md, l, d, f, v, s, rd, h};
    endfunction

    function automatic logic [31:0] expect_now(input logic [15:0] a);
        logic [8:0] r;
        r = m_rdata(a);
        return pack(m_lcdc[7], 2'(m_mode()), 8'(m_ly), 9'(m_dot), m_fd, m_vb,
                    m_line() && !m_lineq, r[7:0], r[8]);
    endfunction

    task automatic model_reset();
        m_lcdc = 8'h91; m_stat = 4'h0; m_lyc = 0; m_ly = 0; m_dot = 0;
        m_m3end = M3END; m_lineq = 1'b0; m_fd = 1'b0; m_vb = 1'b0; m_frames = 0;
    endtask

    task automatic model_step(input bit we, input logic [15:0] a, input logic [7:0] wd, input bit pix);
        bit was_on;
        was_on  = m_lcdc[7];
        m_lineq = m_line();
        m_fd    = 1'b0;
        m_vb    = 1'b0;
        if (was_on && m_mode() == 3 && pix) m_m3end = m_dot;
        if (we) begin
            case (a)
                16'hFF40: m_lcdc = wd;
                16'hFF41: m_stat = wd[6:3];
                16'hFF45: m_lyc  = int'(wd);
                default:  ;
            endcase
        end
        if (!m_lcdc[7] || !was_on) begin
            m_ly = 0; m_dot = 0; m_m3end = M3END;
        end else begin
            m_dot++;
            if (m_dot == CPL) begin
                m_dot = 0; m_ly++; m_m3end = M3END;
                if (m_ly == VIS) m_vb = 1'b1;
                if (m_ly == LPF) begin m_ly = 0; m_fd = 1'b1; m_frames++; end
            end
        end
    endtask

    function automatic logic [15:0] rand_addr();
        case ($urandom_range(0, 5))
            0:       return 16'hFF40;
            1:       return 16'hFF41;
            2:       return 16'hFF44;
            3:       return 16'hFF45;
            4:       return 16'hFF42;
            default: return 16'($urandom);
        endcase
    endfunction

    // drive one cycle, queue the response expected during it, then advance the model on the edge
    task automatic cycle(input bit we, input logic [15:0] a, input logic [7:0] wd, input bit pix);
        reg_write_en = we; reg_addr = a; reg_wdata = wd; pix_done = pix;
        exp_q.push_back(expect_now(a));
        @(posedge clk);
        model_step(we, a, wd, pix);
        #1;
    endtask

    task automatic cycle_auto();
        logic [15:0] a;
        logic [7:0]  wd;
        bit          we;
        bit          pix;
        a = rand_addr(); wd = 8'h00; we = 1'b0;
        if (m_frames == 0) begin
            if      (m_ly == 0   && m_dot == 5)   begin we = 1; a = 16'hFF45; wd = 8'd10; end
            else if (m_ly == 0   && m_dot == 6)   begin we = 1; a = 16'hFF41; wd = 8'h47; end
            else if (m_ly == 12  && m_dot == 0)   begin we = 1; a = 16'hFF41; wd = 8'h28; end
            else if (m_ly == 30  && m_dot == 200) begin we = 1; a = 16'hFF44; wd = 8'h55; end
            else if (m_ly == 40  && m_dot == 300) begin we = 1; a = 16'hFF45; wd = 8'd41; end
            else if (m_ly == 40  && m_dot == 301) begin we = 1; a = 16'hFF41; wd = 8'h68; end
            else if (m_ly == 100 && m_dot == 3)   begin we = 1; a = 16'hFF40; wd = 8'h93; end
        end
        if (m_frames == 0 && m_ly == 0) pix = 1'b0;
        else if (m_ly == 5)             pix = (m_dot == 252);
        else                            pix = ($urandom_range(0, 39) == 0);
        cycle(we, a, wd, pix);
    endtask

    // monitor: compare every presented cycle against the queued expectation
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                if (failures < 40)
                    chk($sformatf("state_cyc%0d", mon_cyc),
                        pack(lcd_on, mode, ly, dot, frame_done, vblank_irq, stat_irq, reg_rdata, reg_hit), e);
                if (frame_done) begin
                    fd_cnt++;
                    chk("frame_done_pos", {ly, 7'd0, dot}, 32'd0);
                    if (fd_cnt == 1) chk("frame_period", mon_cyc, CPL * LPF);
                end
                if (vblank_irq) begin
                    vb_cnt++;
                    chk("vblank_pos", {ly, 7'd0, dot}, {8'd144, 16'd0});
                end
                mon_cyc++;
            end
        end
    end

    initial begin
        int guard;
        reset = 1'b1; reg_write_en = 1'b0; reg_addr = 16'hFF40; reg_wdata = 8'h00; pix_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dot", 32'(dot), 0);
        chk("rst_ly", 32'(ly), 0);
        chk("rst_mode", 32'(mode), 2);
        chk("rst_pulses", {frame_done, vblank_irq, stat_irq}, 0);
        chk("rst_lcdc", {reg_hit, reg_rdata}, 9'h191);
        reg_addr = 16'hFF41; #1;
        chk("rst_stat", {reg_hit, reg_rdata}, 9'h186);
        reg_addr = 16'hFF45; #1;
        chk("rst_lyc", {reg_hit, reg_rdata}, 9'h100);
        reg_addr = 16'hFF42; #1;
        chk("unmapped_read", {reg_hit, reg_rdata}, 9'h000);

        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;

        guard = 0;
        while (!(m_frames == 1 && m_ly == 2 && m_dot == 150) && guard < LIMIT) begin
            cycle_auto();
            guard++;
        end
        if (guard >= LIMIT) begin
            checks++; failures++;
            $display("FAIL frame_loop_bound actual=%0d required<%0d", guard, LIMIT);
        end

        cycle(1'b1, 16'hFF40, 8'h11, 1'b0);
        repeat (30) cycle(1'b0, rand_addr(), 8'h00, 1'($urandom_range(0, 1)));
        cycle(1'b1, 16'hFF40, 8'h91, 1'b0);
        repeat (1100) cycle_auto();

        @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        chk("vblank_count", vb_cnt, 1);
        chk("frame_done_count", fd_cnt, 1);

        @(posedge clk);
        #2;
        reg_addr = 16'hFF45;
        reset = 1'b1;
        #1;
        chk("async_rst_pos", {ly, 7'd0, dot}, 32'd0);
        chk("async_rst_mode", 32'(mode), 2);
        chk("async_rst_pulses", {frame_done, vblank_irq, stat_irq}, 0);
        chk("async_rst_lyc", {reg_hit, reg_rdata}, 9'h100);
        reg_addr = 16'hFF41; #1;
        chk("async_rst_stat", {reg_hit, reg_rdata}, 9'h186);
        reg_addr = 16'hFF40; #1;
        chk("async_rst_lcdc", {reg_hit, reg_rdata}, 9'h191);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
